// File: rtl/program_loader.sv
`default_nettype none
// =============================================================================
// Module      : program_loader
// Description : Frame-driven IMEM loader: assembles LE words from a byte stream,
//               writes them sequentially and holds the CPU in reset until done.
//               Optional trailing checksum byte: PROG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    localparam int         CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             prog_load_en,
    output logic [31:0]      prog_addr,
    output logic [31:0]      prog_data,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [7:0]       c_sync_byte = 8'hA5;
    localparam logic [31:0]      c_max_words = 32'(MAX_WORDS);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK    = 3'd4,
`endif
        ST_ERROR  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      word_q, word_d;
    logic [CNT_W-1:0] words_loaded_q, words_loaded_d;
    logic             prog_load_en_q, prog_load_en_d;
    logic [31:0]      prog_addr_q, prog_addr_d;
    logic [31:0]      prog_data_q, prog_data_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_len_too_big;
    logic        w_last_word;
    logic [31:0] w_word_addr;

    assign rx_ready      = (state_q != ST_ERROR);
    assign w_accept      = rx_valid && rx_ready;
    assign w_len_full    = {rx_data, len_q[7:0]};
    assign w_len_too_big = ({16'd0, w_len_full} > c_max_words);
    assign w_last_word   = ((16'(words_loaded_q) + 16'd1) == len_q);
    assign w_word_addr   = BASE_ADDR + (32'(words_loaded_q) << 2);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byte_idx_d     = byte_idx_q;
        word_d         = word_q;
        words_loaded_d = words_loaded_q;
        prog_load_en_d = 1'b0;
        prog_addr_d    = prog_addr_q;
        prog_data_d    = prog_data_q;
        cpu_reset_d    = cpu_reset_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_accept && (rx_data == c_sync_byte)) begin
                    cpu_reset_d    = 1'b1;
                    load_done_d    = 1'b0;
                    words_loaded_d = '0;
                    byte_idx_d     = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d         = 8'd0;
`endif
                    state_d        = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (w_accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                if (w_accept) begin
                    len_d = w_len_full;
                    if (w_len_too_big) begin
                        load_error_d = 1'b1;
                        cpu_reset_d  = 1'b1;
                        state_d      = ST_ERROR;
                    end else if (w_len_full == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d     = ST_CHK;
`else
                        load_done_d = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (w_accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        // Strobe carries the pre-increment address; count bumps alongside it.
                        prog_load_en_d = 1'b1;
                        prog_addr_d    = w_word_addr;
                        prog_data_d    = {rx_data, word_q};
                        words_loaded_d = words_loaded_q + c_cnt_one;
                        byte_idx_d     = 2'd0;
                        if (w_last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d     = ST_CHK;
`else
                            load_done_d = 1'b1;
                            cpu_reset_d = 1'b0;
                            state_d     = ST_IDLE;
`endif
                        end
                    end else begin
                        case (byte_idx_q)
                            2'd0:    word_d[7:0]   = rx_data;
                            2'd1:    word_d[15:8]  = rx_data;
                            default: word_d[23:16] = rx_data;
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) begin
                    if (rx_data == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        load_error_d = 1'b1;
                        cpu_reset_d  = 1'b1;
                        state_d      = ST_ERROR;
                    end
                end
            end
`endif

            ST_ERROR: begin
                cpu_reset_d  = 1'b1;
                load_error_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            len_q          <= 16'd0;
            byte_idx_q     <= 2'd0;
            word_q         <= 24'd0;
            words_loaded_q <= '0;
            prog_load_en_q <= 1'b0;
            prog_addr_q    <= BASE_ADDR;
            prog_data_q    <= 32'd0;
            cpu_reset_q    <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q         <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_idx_q     <= byte_idx_d;
            word_q         <= word_d;
            words_loaded_q <= words_loaded_d;
            prog_load_en_q <= prog_load_en_d;
            prog_addr_q    <= prog_addr_d;
            prog_data_q    <= prog_data_d;
            cpu_reset_q    <= cpu_reset_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign prog_load_en = prog_load_en_q;
    assign prog_addr    = prog_addr_q;
    assign prog_data    = prog_data_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// =============================================================================
// Module      : tb_program_loader
// Description : Directed, table-driven self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_program_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_load_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [10:0] words_loaded;

    program_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .prog_load_en (prog_load_en),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Strobe log, captured mid-cycle.
    int          strobe_total = 0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];

    always @(negedge clk) begin
        if (prog_load_en === 1'b1) begin
            if (strobe_total < 64) begin
                log_addr[strobe_total] = prog_addr;
                log_data[strobe_total] = prog_data;
            end
            strobe_total = strobe_total + 1;
        end
    end

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cpu_rst;
        logic        done;
        logic        err;
        logic [10:0] words;
    } vec_t;

    vec_t vecs [12];

    logic [7:0]  t2_frame [12];
    logic [31:0] t2_addr  [2];
    logic [31:0] t2_data  [2];
    int          frame_len;
    int          base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_t2(input int max_gap);
        for (int k = 0; k < frame_len; k++)
            send(t2_frame[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_t2_writes(input string tag, input int from);
        check({tag, "_strobes"}, 32'(strobe_total - from), 32'd2);
        for (int k = 0; k < 2; k++) begin
            if (from + k < 64) begin
                check($sformatf("%s_addr%0d", tag, k), log_addr[from + k], t2_addr[k]);
                check($sformatf("%s_data%0d", tag, k), log_data[from + k], t2_data[k]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        t2_frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        t2_addr  = '{32'h0, 32'h4};
        t2_data  = '{32'h0000_0013, 32'h0010_0093};
        frame_len = CHK_ON ? 12 : 11;

        //          vld   byte   rdy   en    addr   wdata          cpu     done    err   words
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1,   1'b0,   1'b0, 11'd0};
        vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1,   1'b0,   1'b0, 11'd0};
        vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1,   1'b0,   1'b0, 11'd0};
        vecs[3]  = '{1'b1, 8'h13, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1,   1'b0,   1'b0, 11'd0};
        vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1,   1'b0,   1'b0, 11'd0};
        vecs[5]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1,   1'b0,   1'b0, 11'd0};
        vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b1, 32'h0, 32'h13,       1'b1,   1'b0,   1'b0, 11'd1};
        vecs[7]  = '{1'b1, 8'h93, 1'b1, 1'b0, 32'h0, 32'h13,       1'b1,   1'b0,   1'b0, 11'd1};
        vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 32'h0, 32'h13,       1'b1,   1'b0,   1'b0, 11'd1};
        vecs[9]  = '{1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 32'h13,       1'b1,   1'b0,   1'b0, 11'd1};
        vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 32'h4, 32'h0010_0093, CHK_ON, !CHK_ON, 1'b0, 11'd2};
        vecs[11] = '{CHK_ON, 8'hB6, 1'b1, 1'b0, 32'h4, 32'h0010_0093, 1'b0, 1'b1,  1'b0, 11'd2};

        // T1: reset values
        do_reset();
        check("t1_rx_ready",     32'(rx_ready),     32'd1);
        check("t1_cpu_reset",    32'(cpu_reset),    32'd1);
        check("t1_prog_load_en", 32'(prog_load_en), 32'd0);
        check("t1_load_done",    32'(load_done),    32'd0);
        check("t1_load_error",   32'(load_error),   32'd0);
        check("t1_words_loaded", 32'(words_loaded), 32'd0);
        check("t1_prog_addr",    prog_addr,         32'd0);
        check("t1_prog_data",    prog_data,         32'd0);

        // T2: back-to-back frame, cycle-exact
        base = strobe_total;
        for (int i = 0; i < 12; i++) begin
            rx_valid = vecs[i].valid;
            rx_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("t2_v%0d_ready", i), 32'(rx_ready),     32'(vecs[i].ready));
            check($sformatf("t2_v%0d_en", i),    32'(prog_load_en), 32'(vecs[i].en));
            check($sformatf("t2_v%0d_addr", i),  prog_addr,         vecs[i].addr);
            check($sformatf("t2_v%0d_data", i),  prog_data,         vecs[i].wdata);
            check($sformatf("t2_v%0d_cpu", i),   32'(cpu_reset),    32'(vecs[i].cpu_rst));
            check($sformatf("t2_v%0d_done", i),  32'(load_done),    32'(vecs[i].done));
            check($sformatf("t2_v%0d_err", i),   32'(load_error),   32'(vecs[i].err));
            check($sformatf("t2_v%0d_words", i), 32'(words_loaded), 32'(vecs[i].words));
        end
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check_t2_writes("t2", base);

        // T3: leading junk, then gapped frame
        do_reset();
        base = strobe_total;
        send(8'h00, 2);
        send(8'hFF, 0);
        send(8'h5A, 3);
        check("t3_junk_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_junk_done",      32'(load_done), 32'd0);
        send_t2(5);
        check_t2_writes("t3", base);
        check("t3_done",      32'(load_done),    32'd1);
        check("t3_cpu_reset", 32'(cpu_reset),    32'd0);
        check("t3_words",     32'(words_loaded), 32'd2);

        // LEN == 0 completes with no writes
        do_reset();
        base = strobe_total;
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        if (CHK_ON) send(8'h00, 0);
        @(posedge clk);
        #1;
        check("len0_done",      32'(load_done),            32'd1);
        check("len0_cpu_reset", 32'(cpu_reset),            32'd0);
        check("len0_strobes",   32'(strobe_total - base),  32'd0);

        // 0xA5 inside DATA is payload
        do_reset();
        base = strobe_total;
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hA5, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        if (CHK_ON) send(8'h0B, 0);
        @(posedge clk);
        #1;
        check("a5data_strobes", 32'(strobe_total - base), 32'd1);
        if (base < 64) check("a5data_word", log_data[base], 32'h3322_11A5);
        check("a5data_done",  32'(load_done),    32'd1);
        check("a5data_words", 32'(words_loaded), 32'd1);

        // LEN == MAX_WORDS is legal
        do_reset();
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h04, 0);
        check("lenmax_error", 32'(load_error), 32'd0);
        check("lenmax_ready", 32'(rx_ready),   32'd1);

        // T4: LEN == MAX_WORDS+1 rejected, sticky
        do_reset();
        base = strobe_total;
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h04, 0);
        check("t4_error",     32'(load_error), 32'd1);
        check("t4_ready",     32'(rx_ready),   32'd0);
        check("t4_cpu_reset", 32'(cpu_reset),  32'd1);
        send_t2(0);
        check("t4_error_hold", 32'(load_error),           32'd1);
        check("t4_ready_hold", 32'(rx_ready),             32'd0);
        check("t4_done",       32'(load_done),            32'd0);
        check("t4_words",      32'(words_loaded),         32'd0);
        check("t4_strobes",    32'(strobe_total - base),  32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // T5: bad checksum after both words written
        do_reset();
        base = strobe_total;
        t2_frame[11] = 8'hB7;
        send_t2(0);
        t2_frame[11] = 8'hB6;
        check_t2_writes("t5", base);
        check("t5_error",     32'(load_error), 32'd1);
        check("t5_cpu_reset", 32'(cpu_reset),  32'd1);
        check("t5_done",      32'(load_done),  32'd0);
`endif

        // T6: reset mid-load after 6 data bytes
        do_reset();
        base = strobe_total;
        for (int k = 0; k < 9; k++) send(t2_frame[k], 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_en",    32'(prog_load_en), 32'd0);
        check("t6_rst_ready", 32'(rx_ready),     32'd1);
        check("t6_rst_cpu",   32'(cpu_reset),    32'd1);
        check("t6_rst_words", 32'(words_loaded), 32'd0);
        check("t6_rst_addr",  prog_addr,         32'd0);
        check("t6_rst_data",  prog_data,         32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_strobes", 32'(strobe_total - base), 32'd1);
        base = strobe_total;
        send_t2(0);
        check_t2_writes("t6_fresh", base);
        check("t6_done",  32'(load_done),    32'd1);
        check("t6_words", 32'(words_loaded), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
